// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit.
// Drives a single-port data bus (req/gnt/rvalid), builds byte enables and
// lane-replicated store data, and aligns/extends load data into ReadDataM.
// StallM holds the upstream pipeline while an access is in flight.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   When defined, a misaligned access issues no bus request; the unit goes
//   straight to DONE, where MisalignM pulses for one cycle with StallM low
//   (loads also clear ReadDataM). When undefined, MisalignM is tied low and
//   the low address bits that do not fit the access size are ignored.
module mem_stage_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [2:0]      funct3M,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallM,
  output logic            MisalignM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state_reg;
  logic [1:0]  ld_off_reg;
  logic [2:0]  ld_f3_reg;

  logic        is_load;
  logic        is_store;
  logic        acc;
  logic [1:0]  offset;
  logic        size_byte;
  logic        size_half;
  logic        trap;

  logic [3:0]      store_be;
  logic [XLEN-1:0] store_wdata;
  logic [7:0]      rd_byte [4];
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [XLEN-1:0] load_ext;

  // Access decode. A load wins if both flags were ever set together.
  assign is_load   = (ResultSrcM == 2'b01);
  assign is_store  = MemWriteM & ~is_load;
  assign acc       = is_load | MemWriteM;
  assign offset    = ALUResultM[1:0];

  // Size decode: stores only know sb/sh/sw; lbu/lhu add the unsigned loads.
  // Every remaining funct3 value behaves as a full word.
  assign size_byte = (funct3M == 3'b000) | (is_load & (funct3M == 3'b100));
  assign size_half = (funct3M == 3'b001) | (is_load & (funct3M == 3'b101));

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_reg;

  assign misaligned = size_half ? offset[0] : (~size_byte & (offset != 2'b00));
  assign trap       = acc & misaligned;
  assign MisalignM  = misalign_reg & ~reset;
`else
  assign trap       = 1'b0;
  assign MisalignM  = 1'b0;
`endif

  // Bus address is always word aligned; lane choice is carried by mem_be.
  assign mem_addr = {ALUResultM[XLEN-1:2], 2'b00};

  // Store byte enables: one lane for sb, a lane pair chosen by offset[1] for sh.
  always_comb begin
    store_be = 4'b1111;
    if (size_byte) begin
      store_be = 4'b0001 << offset;
    end else if (size_half) begin
      store_be = 4'b0011 << {offset[1], 1'b0};
    end
  end

  // Store data replication: each lane gets the byte it would hold for any
  // legal offset, so the enables alone decide what is written.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
      assign store_wdata[8*gi +: 8] = size_byte ? WriteDataM[7:0] :
                                      size_half ? WriteDataM[8*(gi%2) +: 8] :
                                                  WriteDataM[8*gi +: 8];
    end
  endgenerate

  assign mem_we    = is_store;
  assign mem_be    = is_store ? store_be : 4'b1111;
  assign mem_wdata = store_wdata;

  // Split the returned word into lanes for byte selection.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_load_lane
      assign rd_byte[gi] = mem_rdata[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = rd_byte[ld_off_reg];
  assign sel_half = ld_off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  // Load alignment and extension using the offset/funct3 captured at request.
  always_comb begin
    load_ext = mem_rdata;
    case (ld_f3_reg)
      3'b000:  load_ext = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, sel_byte};
      3'b001:  load_ext = {{(XLEN-16){sel_half[15]}}, sel_half};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, sel_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Bus request and pipeline stall; IDLE answers combinationally so a granted
  // access costs no extra cycle. Both are forced low while reset is asserted.
  always_comb begin
    mem_req = 1'b0;
    StallM  = 1'b0;
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          mem_req = acc & ~trap;
          StallM  = acc;
        end
        WAIT_GNT: begin
          mem_req = 1'b1;
          StallM  = 1'b1;
        end
        WAIT_RSP: begin
          StallM  = 1'b1;
        end
        default: begin
          mem_req = 1'b0;
          StallM  = 1'b0;
        end
      endcase
    end
  end

  // Access sequencer: state, captured load lane info and the load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      ReadDataM  <= '0;
      ld_off_reg <= 2'b00;
      ld_f3_reg  <= 3'b000;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (acc) begin
            ld_off_reg <= offset;
            ld_f3_reg  <= funct3M;
            if (trap) begin
              state_reg <= DONE;
              if (is_load) begin
                ReadDataM <= '0;
              end
`ifdef LSU_MISALIGN_TRAP_EN
              misalign_reg <= 1'b1;
`endif
            end else if (mem_gnt) begin
              state_reg <= is_load ? WAIT_RSP : DONE;
            end else begin
              state_reg <= WAIT_GNT;
            end
          end
        end
        WAIT_GNT: begin
          ld_off_reg <= offset;
          ld_f3_reg  <= funct3M;
          if (mem_gnt) begin
            state_reg <= is_load ? WAIT_RSP : DONE;
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid) begin
            ReadDataM <= load_ext;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
          misalign_reg <= 1'b0;
`endif
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed plus randomized bench for mem_stage_lsu.
// A byte-addressed memory image answers the bus and also drives the expected
// values for byte enables, store data and extended load results.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [2:0]  funct3M;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  // Memory image covering byte addresses 0x100..0x13F.
  logic [7:0] mem_b [64];

  mem_stage_lsu #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .funct3M    (funct3M),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from the instruction rules.
  function automatic int size_of(input bit st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  // First memory byte touched: low address bits beyond the size are dropped.
  function automatic int base_idx(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = size_of(st, f3);
    if (sz == 4) return int'(a & 32'hFFFF_FFFC) - 256;
    if (sz == 2) return int'(a & 32'hFFFF_FFFE) - 256;
    return int'(a) - 256;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    int w;
    w = int'(a & 32'hFFFF_FFFC) - 256;
    return {mem_b[w+3], mem_b[w+2], mem_b[w+1], mem_b[w]};
  endfunction

  function automatic logic [3:0] exp_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = size_of(st, f3);
    if (!st || sz == 4) return 4'hF;
    if (sz == 1) return 4'(1 << (a % 4));
    return 4'(3 << ((a % 4) & 2));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz;
    sz = size_of(1'b1, f3);
    if (sz == 1) return 32'(d[7:0]) * 32'h0101_0101;
    if (sz == 2) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  // Load result: gather bytes little-endian, then sign-extend arithmetically.
  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a);
    int     sz;
    int     b;
    longint raw;
    sz  = size_of(1'b0, f3);
    b   = base_idx(1'b0, f3, a);
    raw = 0;
    for (int i = 0; i < sz; i++) raw += longint'(mem_b[b+i]) << (8*i);
    if (!f3[2] && sz < 4 && raw >= (longint'(1) << (8*sz-1)))
      raw -= (longint'(1) << (8*sz));
    return 32'(raw);
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    int b;
    b = int'(a & 32'hFFFF_FFFC) - 256;
    for (int i = 0; i < 4; i++) mem_b[b+i] = w[8*i +: 8];
  endtask

  // One complete access; entered and left just after a falling edge with the
  // unit idle. gd = cycles before gnt, rd = cycles from gnt to rvalid.
  task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int gd, input int rd, input string tag);
    logic [31:0] exp_rd;
    logic [31:0] rword;
    bit          granted;
    bit          finished;
    int          gc;
    exp_rd   = st ? ReadDataM : load_model(f3, a);
    rword    = word_of(a);
    granted  = 1'b0;
    finished = 1'b0;
    gc       = 0;
    MemWriteM  = st;
    ResultSrcM = st ? 2'b00 : 2'b01;
    ALUResultM = a;
    WriteDataM = d;
    funct3M    = f3;
    for (int c = 0; c < 40 && !finished; c++) begin
      if (!granted) begin
        mem_gnt    = (c >= gd);
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        #1;
        chk({tag, "_req"},   mem_req, 1);
        chk({tag, "_stall"}, StallM, 1);
        chk({tag, "_addr"},  mem_addr, a & 32'hFFFF_FFFC);
        chk({tag, "_we"},    mem_we, st);
        chk({tag, "_be"},    mem_be, exp_be(st, f3, a));
        if (st) chk({tag, "_wdata"}, mem_wdata, exp_wdata(f3, d));
        if (mem_gnt) begin
          granted = 1'b1;
          gc      = c;
        end
      end else if (!st && (c - gc) <= rd) begin
        mem_gnt    = 1'($urandom_range(0, 1));
        mem_rvalid = ((c - gc) == rd);
        mem_rdata  = mem_rvalid ? rword : $urandom;
        #1;
        chk({tag, "_rsp_req"},   mem_req, 0);
        chk({tag, "_rsp_stall"}, StallM, 1);
      end else begin
        mem_gnt    = 1'($urandom_range(0, 1));
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        #1;
        chk({tag, "_done_stall"}, StallM, 0);
        chk({tag, "_done_req"},   mem_req, 0);
        chk({tag, "_done_mis"},   MisalignM, 0);
        chk({tag, "_rdata"},      ReadDataM, exp_rd);
        finished = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!finished) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s_timeout: observed no completion expected completion", tag);
    end
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    chk({tag, "_idle_stall"}, StallM, 0);
    chk({tag, "_hold"},       ReadDataM, exp_rd);
    if (st) begin
      for (int i = 0; i < size_of(1'b1, f3); i++)
        mem_b[base_idx(1'b1, f3, a) + i] = d[8*i +: 8];
    end
    $display("txn %s st=%0d f3=%0d addr=%h data=%h gd=%0d rd=%0d ReadDataM=%h",
             tag, st, f3, a, d, gd, rd, ReadDataM);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rdat;
    logic [2:0]  rf3;
    bit          rst_st;

    reset = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b00; ALUResultM = '0;
    WriteDataM = '0; funct3M = 3'b000; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rdata", ReadDataM, 0);
    chk("rst_stall", StallM, 0);
    chk("rst_req",   mem_req, 0);
    chk("rst_mis",   MisalignM, 0);
    reset = 1'b0;
    @(negedge clk);

    // sw / sb
    do_access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, "sw_100");
    do_access(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 0, 0, "sb_103");
    chk("sb_word", word_of(32'h100), 32'hA5AD_BEEF);

    // Byte/halfword loads from a known word
    set_word(32'h100, 32'h12F0_3456);
    do_access(1'b0, 3'b000, 32'h102, 32'h0, 0, 1, "lb_102");
    chk("lb_const", ReadDataM, 32'hFFFF_FFF0);
    do_access(1'b0, 3'b100, 32'h102, 32'h0, 0, 1, "lbu_102");
    chk("lbu_const", ReadDataM, 32'h0000_00F0);
    do_access(1'b0, 3'b101, 32'h102, 32'h0, 0, 1, "lhu_102");
    chk("lhu_const", ReadDataM, 32'h0000_12F0);

    // lw with grant held off 3 cycles and response 2 cycles after grant
    set_word(32'h120, 32'h5A5A_1234);
    do_access(1'b0, 3'b010, 32'h120, 32'h0, 3, 2, "lw_wait");
    chk("lw_const", ReadDataM, 32'h5A5A_1234);

    // Reset while waiting for a response; the late rvalid must be dropped
    MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h104;
    mem_gnt = 1'b1; mem_rvalid = 1'b0;
    #1;
    chk("rm_req", mem_req, 1);
    @(posedge clk);
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    chk("rm_wait_stall", StallM, 1);
    reset = 1'b1; ResultSrcM = 2'b00;
    #1;
    chk("rm_rst_stall", StallM, 0);
    chk("rm_rst_req",   mem_req, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("rm_late_stall", StallM, 0);
    chk("rm_late_req",   mem_req, 0);
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("rm_rdata", ReadDataM, 0);
    chk("rm_stall", StallM, 0);
    $display("txn rst_mid ReadDataM=%h StallM=%0d", ReadDataM, StallM);

    // Misaligned halfword load
    set_word(32'h100, 32'h1234_8765);
`ifdef LSU_MISALIGN_TRAP_EN
    MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'b001; ALUResultM = 32'h101;
    mem_gnt = 1'b1;
    #1;
    chk("mis_req", mem_req, 0);
    chk("mis_pre", MisalignM, 0);
    @(posedge clk);
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    chk("mis_pulse", MisalignM, 1);
    chk("mis_stall", StallM, 0);
    chk("mis_rdata", ReadDataM, 0);
    @(posedge clk);
    @(negedge clk);
    ResultSrcM = 2'b00;
    #1;
    chk("mis_clear", MisalignM, 0);
    $display("txn lh_misal_trap ReadDataM=%h", ReadDataM);
`else
    do_access(1'b0, 3'b001, 32'h101, 32'h0, 0, 1, "lh_misal");
    chk("lh_misal_const", ReadDataM, 32'hFFFF_8765);
`endif

    // Randomized accesses against the memory image
    for (int n = 0; n < 40; n++) begin
      rst_st = 1'($urandom_range(0, 1));
      rf3    = 3'($urandom_range(0, 7));
      ra     = 32'h100 + 32'($urandom_range(0, 63));
`ifdef LSU_MISALIGN_TRAP_EN
      ra     = ra & ~(32'(size_of(rst_st, rf3)) - 32'd1);
`endif
      rdat   = $urandom;
      do_access(rst_st, rf3, ra, rdat, int'($urandom_range(0, 3)),
                int'($urandom_range(1, 3)), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
